npc_sram: RTL and testbench

NPC_SRAM -- requirements
Module: npc_sram

---
 rtl/npc_sram.sv | 264 ++++++++++++++++++++++++++
 tb/tb_npc_sram.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/npc_sram.sv
// npc_sram: word-addressed 32-bit SRAM behind a simplified AXI slave.
// The read and write channels run independent FSMs and share one byte-lane memory.
// Define NPC_SRAM_DELAY_EN to insert LAT cycles of extra response delay
// on both channels. Without it, the response follows the last handshake by one cycle.

package npc_sram_pkg;
    typedef struct packed {
        logic        awvalid;
        logic [31:0] awaddr;
        logic [7:0]  awlen;
        logic [2:0]  awsize;
        logic [1:0]  awburst;
        logic        wvalid;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        wlast;
        logic        bready;
    } axi_w_m2s_t;

    typedef struct packed {
        logic awready;
        logic wready;
        logic bvalid;
    } axi_w_s2m_t;

    typedef struct packed {
        logic        arvalid;
        logic [31:0] araddr;
        logic [7:0]  arlen;
        logic [2:0]  arsize;
        logic [1:0]  arburst;
        logic        rready;
    } axi_r_m2s_t;

    typedef struct packed {
        logic        arready;
        logic        rvalid;
        logic [31:0] rdata;
        logic        rlast;
    } axi_r_s2m_t;
endpackage

module npc_sram
    import npc_sram_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LAT         = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  axi_w_m2s_t sram_w_m2s,
    output axi_w_s2m_t sram_w_s2m,
    input  axi_r_m2s_t sram_r_m2s,
    output axi_r_s2m_t sram_r_s2m
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

`ifdef NPC_SRAM_DELAY_EN
    localparam logic [31:0] LAT_U = LAT;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_t;
    logic [31:0] r_wait_reg, r_wait_next;
    logic [31:0] w_wait_reg, w_wait_next;
`else
    localparam int lat_unused = LAT;
    typedef enum logic [1:0] {R_IDLE, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
`endif

    r_state_t    r_state_reg, r_state_next;
    logic [31:0] r_addr_reg, r_addr_next;
    logic [7:0]  r_len_reg, r_len_next;
    logic [2:0]  r_size_reg, r_size_next;
    logic [1:0]  r_burst_reg, r_burst_next;
    logic [7:0]  r_beat_reg, r_beat_next;

    w_state_t    w_state_reg, w_state_next;
    logic [31:0] w_addr_reg, w_addr_next;
    logic [7:0]  w_len_unused_reg, w_len_next;
    logic [2:0]  w_size_reg, w_size_next;
    logic [1:0]  w_burst_reg, w_burst_next;

    logic ar_ready, r_valid, r_last, aw_ready, w_ready, b_valid, w_fire;
    logic [31:0] r_word, r_off, w_off;
    logic [IDX_W-1:0] r_idx, w_idx;
    logic unused_bits;

    // Next beat address: FIXED bursts stay put, INCR/WRAP step by the transfer size
    function automatic logic [31:0] step_addr(input logic [31:0] a, input logic [2:0] size,
                                              input logic [1:0] burst);
        return (burst == 2'b00) ? a : a + (32'd1 << size);
    endfunction

    // Out-of-range addresses simply wrap onto the storage by dropping high index bits
    assign r_off = r_addr_reg - ADDR_BASE;
    assign w_off = w_addr_reg - ADDR_BASE;
    assign r_idx = r_off[IDX_W+1:2];
    assign w_idx = w_off[IDX_W+1:2];
    assign unused_bits = &{1'b0, r_off[31:IDX_W+2], r_off[1:0], w_off[31:IDX_W+2], w_off[1:0]};

    assign w_fire = w_ready & sram_w_m2s.wvalid;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];
            // Byte-lane store; contents survive reset, read side is combinational
            always_ff @(posedge clock) begin
                if (w_fire && sram_w_m2s.wstrb[gi]) begin
                    lane_mem[w_idx] <= sram_w_m2s.wdata[8*gi +: 8];
                end
            end
            assign r_word[8*gi +: 8] = lane_mem[r_idx];
        end
    endgenerate

    // Read and write FSM state registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state_reg      <= R_IDLE;
            r_addr_reg       <= '0;
            r_len_reg        <= '0;
            r_size_reg       <= '0;
            r_burst_reg      <= '0;
            r_beat_reg       <= '0;
            w_state_reg      <= W_IDLE;
            w_addr_reg       <= '0;
            w_len_unused_reg <= '0;
            w_size_reg       <= '0;
            w_burst_reg      <= '0;
`ifdef NPC_SRAM_DELAY_EN
            r_wait_reg       <= '0;
            w_wait_reg       <= '0;
`endif
        end else begin
            r_state_reg      <= r_state_next;
            r_addr_reg       <= r_addr_next;
            r_len_reg        <= r_len_next;
            r_size_reg       <= r_size_next;
            r_burst_reg      <= r_burst_next;
            r_beat_reg       <= r_beat_next;
            w_state_reg      <= w_state_next;
            w_addr_reg       <= w_addr_next;
            w_len_unused_reg <= w_len_next;
            w_size_reg       <= w_size_next;
            w_burst_reg      <= w_burst_next;
`ifdef NPC_SRAM_DELAY_EN
            r_wait_reg       <= r_wait_next;
            w_wait_reg       <= w_wait_next;
`endif
        end
    end

    // Read FSM: accept AR, optionally delay, then stream beats from the combinational read
    always_comb begin
        r_state_next = r_state_reg;
        r_addr_next  = r_addr_reg;
        r_len_next   = r_len_reg;
        r_size_next  = r_size_reg;
        r_burst_next = r_burst_reg;
        r_beat_next  = r_beat_reg;
`ifdef NPC_SRAM_DELAY_EN
        r_wait_next  = r_wait_reg;
`endif
        ar_ready = 1'b0;
        r_valid  = 1'b0;
        r_last   = 1'b0;
        case (r_state_reg)
            R_IDLE: begin
                ar_ready = !reset;
                if (ar_ready && sram_r_m2s.arvalid) begin
                    r_addr_next  = sram_r_m2s.araddr;
                    r_len_next   = sram_r_m2s.arlen;
                    r_size_next  = sram_r_m2s.arsize;
                    r_burst_next = sram_r_m2s.arburst;
                    r_beat_next  = '0;
`ifdef NPC_SRAM_DELAY_EN
                    r_wait_next  = '0;
                    r_state_next = R_WAIT;
`else
                    r_state_next = R_DATA;
`endif
                end
            end
`ifdef NPC_SRAM_DELAY_EN
            R_WAIT: begin
                if (r_wait_reg + 32'd1 >= LAT_U) r_state_next = R_DATA;
                else                             r_wait_next  = r_wait_reg + 32'd1;
            end
`endif
            R_DATA: begin
                r_valid = !reset;
                r_last  = !reset && (r_beat_reg == r_len_reg);
                if (r_valid && sram_r_m2s.rready) begin
                    if (r_last) begin
                        r_state_next = R_IDLE;
                    end else begin
                        r_beat_next = r_beat_reg + 8'd1;
                        r_addr_next = step_addr(r_addr_reg, r_size_reg, r_burst_reg);
                    end
                end
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    // Write FSM: accept AW, take beats until wlast, optionally delay, then respond
    always_comb begin
        w_state_next = w_state_reg;
        w_addr_next  = w_addr_reg;
        w_len_next   = w_len_unused_reg;
        w_size_next  = w_size_reg;
        w_burst_next = w_burst_reg;
`ifdef NPC_SRAM_DELAY_EN
        w_wait_next  = w_wait_reg;
`endif
        aw_ready = 1'b0;
        w_ready  = 1'b0;
        b_valid  = 1'b0;
        case (w_state_reg)
            W_IDLE: begin
                aw_ready = !reset;
                if (aw_ready && sram_w_m2s.awvalid) begin
                    w_addr_next  = sram_w_m2s.awaddr;
                    w_len_next   = sram_w_m2s.awlen;
                    w_size_next  = sram_w_m2s.awsize;
                    w_burst_next = sram_w_m2s.awburst;
                    w_state_next = W_DATA;
                end
            end
            W_DATA: begin
                w_ready = !reset;
                if (w_ready && sram_w_m2s.wvalid) begin
                    w_addr_next = step_addr(w_addr_reg, w_size_reg, w_burst_reg);
                    if (sram_w_m2s.wlast) begin
`ifdef NPC_SRAM_DELAY_EN
                        w_wait_next  = '0;
                        w_state_next = W_WAIT;
`else
                        w_state_next = W_RESP;
`endif
                    end
                end
            end
`ifdef NPC_SRAM_DELAY_EN
            W_WAIT: begin
                if (w_wait_reg + 32'd1 >= LAT_U) w_state_next = W_RESP;
                else                             w_wait_next  = w_wait_reg + 32'd1;
            end
`endif
            W_RESP: begin
                b_valid = !reset;
                if (b_valid && sram_w_m2s.bready) w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    assign sram_r_s2m = '{arready: ar_ready, rvalid: r_valid, rdata: r_word, rlast: r_last};
    assign sram_w_s2m = '{awready: aw_ready, wready: w_ready, bvalid: b_valid};

endmodule

// File: tb/tb_npc_sram.sv
// Directed testbench for npc_sram: single and burst transfers, byte strobes,
// stalls, same-cycle read/write, reset mid-burst and address aliasing.
module tb_npc_sram;
    import npc_sram_pkg::*;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 4096;
    localparam int          LAT   = 4;
`ifdef NPC_SRAM_DELAY_EN
    localparam int EXP_LAT = 1 + LAT;
`else
    localparam int EXP_LAT = 1;
`endif

    logic       clock = 1'b0;
    logic       reset;
    axi_w_m2s_t w_m2s;
    axi_w_s2m_t w_s2m;
    axi_r_m2s_t r_m2s;
    axi_r_s2m_t r_s2m;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] model [16];

    always #5 clock = ~clock;

    npc_sram #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .LAT(LAT)) dut (
        .clock      (clock),
        .reset      (reset),
        .sram_w_m2s (w_m2s),
        .sram_w_s2m (w_s2m),
        .sram_r_m2s (r_m2s),
        .sram_r_s2m (r_s2m)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return r_s2m.arready;
            1:       return w_s2m.awready;
            2:       return w_s2m.wready;
            3:       return r_s2m.rvalid;
            default: return w_s2m.bvalid;
        endcase
    endfunction

    // Called at a negedge; waits (bounded) until the selected signal is high
    task automatic wait_for(input int sel, input string tag, output int cyc);
        cyc = 0;
        while (!sig(sel) && cyc < 40) begin
            @(negedge clock);
            cyc++;
        end
        if (!sig(sel)) check({tag, "_timeout"}, 32'(sig(sel)), 32'd1);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] d0,
                            input int nbeats, input logic [1:0] burst);
        int c;
        logic [31:0] off;
        logic [3:0]  widx;
        off = addr - BASE;
        w_m2s.awvalid = 1'b1;
        w_m2s.awaddr  = addr;
        w_m2s.awlen   = 8'(nbeats - 1);
        w_m2s.awsize  = 3'd2;
        w_m2s.awburst = burst;
        wait_for(1, "awready", c);
        @(posedge clock); @(negedge clock);
        w_m2s.awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            w_m2s.wvalid = 1'b1;
            w_m2s.wdata  = d0 + 32'(i);
            w_m2s.wstrb  = strb;
            w_m2s.wlast  = (i == nbeats - 1);
            wait_for(2, "wready", c);
            @(posedge clock); @(negedge clock);
            widx = (burst == 2'b00) ? off[5:2] : off[5:2] + 4'(i);
            for (int j = 0; j < 4; j++)
                if (strb[j]) model[widx][8*j +: 8] = w_m2s.wdata[8*j +: 8];
        end
        w_m2s.wvalid = 1'b0;
        w_m2s.wlast  = 1'b0;
        wait_for(4, "bvalid", c);
        check("b_latency", 32'(c + 1), 32'(EXP_LAT));
        w_m2s.bready = 1'b1;
        @(posedge clock); @(negedge clock);
        w_m2s.bready = 1'b0;
        check("b_cleared", 32'(w_s2m.bvalid), 32'd0);
        $display("WR addr=%h beats=%0d strb=%h d0=%h blat=%0d", addr, nbeats, strb, d0, c + 1);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input bit toggle, output logic [31:0] first_data);
        int c, beat, k;
        logic [31:0] off;
        logic [3:0]  widx;
        first_data = '0;
        off = addr - BASE;
        r_m2s.arvalid = 1'b1;
        r_m2s.araddr  = addr;
        r_m2s.arlen   = len;
        r_m2s.arsize  = 3'd2;
        r_m2s.arburst = burst;
        r_m2s.rready  = 1'b0;
        wait_for(0, "arready", c);
        @(posedge clock); @(negedge clock);
        r_m2s.arvalid = 1'b0;
        wait_for(3, "rvalid", c);
        check("r_latency", 32'(c + 1), 32'(EXP_LAT));
        beat = 0;
        k = 0;
        while (beat <= int'(len) && k < 64) begin
            if (!r_s2m.rvalid) begin
                check("rvalid_dropped", 32'(r_s2m.rvalid), 32'd1);
                break;
            end
            widx = (burst == 2'b00) ? off[5:2] : off[5:2] + 4'(beat);
            check("rdata", r_s2m.rdata, model[widx]);
            check("rlast", 32'(r_s2m.rlast), 32'(beat == int'(len)));
            if (beat == 0) first_data = r_s2m.rdata;
            r_m2s.rready = toggle ? (k % 2 == 0) : 1'b1;
            @(posedge clock); @(negedge clock);
            if (r_m2s.rready) beat++;
            k++;
        end
        r_m2s.rready = 1'b0;
        check("r_done_arready", 32'(r_s2m.arready), 32'd1);
        $display("RD addr=%h len=%0d burst=%0d first=%h rlat=%0d", addr, len, burst, first_data, c + 1);
    endtask

    initial begin
        int c;
        logic [31:0] d;
        reset = 1'b1;
        w_m2s = '0;
        r_m2s = '0;
        for (int i = 0; i < 16; i++) model[i] = '0;

        // Outputs quiet during reset, IDLE readiness right after release
        @(posedge clock); @(negedge clock);
        check("rst_arready", 32'(r_s2m.arready), 32'd0);
        check("rst_awready", 32'(w_s2m.awready), 32'd0);
        check("rst_wready",  32'(w_s2m.wready),  32'd0);
        check("rst_rvalid",  32'(r_s2m.rvalid),  32'd0);
        check("rst_bvalid",  32'(w_s2m.bvalid),  32'd0);
        @(posedge clock); @(negedge clock);
        reset = 1'b0;
        @(posedge clock); @(negedge clock);
        check("idle_arready", 32'(r_s2m.arready), 32'd1);
        check("idle_awready", 32'(w_s2m.awready), 32'd1);

        // Full-word write then read back
        do_write(32'h8000_0010, 4'hF, 32'hDEAD_BEEF, 1, 2'b01);
        do_read(32'h8000_0010, 8'd0, 2'b01, 1'b0, d);
        check("deadbeef", d, 32'hDEAD_BEEF);

        // Byte-strobe merge
        do_write(32'h8000_0020, 4'hF, 32'hFFFF_FFFF, 1, 2'b01);
        do_write(32'h8000_0020, 4'b0101, 32'h1122_3344, 1, 2'b01);
        do_read(32'h8000_0020, 8'd0, 2'b01, 1'b0, d);
        check("wstrb_merge", d, 32'hFF22_FF44);

        // INCR burst write of words 0..3, then 4-beat read with rready toggling
        do_write(32'h8000_0000, 4'hF, 32'h0000_1000, 4, 2'b01);
        do_read(32'h8000_0000, 8'd3, 2'b01, 1'b1, d);
        check("incr_first", d, 32'h0000_1000);

        // FIXED bursts: read repeats one word, write lands every beat on one word
        do_read(32'h8000_0010, 8'd1, 2'b00, 1'b0, d);
        do_write(32'h8000_0024, 4'hF, 32'h7700_0000, 2, 2'b00);
        do_read(32'h8000_0024, 8'd0, 2'b01, 1'b0, d);
        check("fixed_write", d, 32'h7700_0001);

        // Same-word read and write in one cycle: old data that cycle, new data next
        do_write(32'h8000_0014, 4'hF, 32'h0000_5555, 1, 2'b01);
        r_m2s.arvalid = 1'b1; r_m2s.araddr = 32'h8000_0014; r_m2s.arlen = 8'd0;
        r_m2s.arsize = 3'd2;  r_m2s.arburst = 2'b01;        r_m2s.rready = 1'b0;
        wait_for(0, "rw_arready", c);
        @(posedge clock); @(negedge clock);
        r_m2s.arvalid = 1'b0;
        wait_for(3, "rw_rvalid", c);
        check("rw_before", r_s2m.rdata, 32'h0000_5555);
        w_m2s.awvalid = 1'b1; w_m2s.awaddr = 32'h8000_0014; w_m2s.awlen = 8'd0;
        w_m2s.awsize = 3'd2;  w_m2s.awburst = 2'b01;
        wait_for(1, "rw_awready", c);
        @(posedge clock); @(negedge clock);
        w_m2s.awvalid = 1'b0;
        w_m2s.wvalid = 1'b1; w_m2s.wdata = 32'h0000_AAAA; w_m2s.wstrb = 4'hF; w_m2s.wlast = 1'b1;
        wait_for(2, "rw_wready", c);
        check("rw_same_cycle", r_s2m.rdata, 32'h0000_5555);
        @(posedge clock); @(negedge clock);
        w_m2s.wvalid = 1'b0; w_m2s.wlast = 1'b0;
        check("rw_next_cycle", r_s2m.rdata, 32'h0000_AAAA);
        model[5] = 32'h0000_AAAA;
        w_m2s.bready = 1'b1;
        wait_for(4, "rw_bvalid", c);
        @(posedge clock); @(negedge clock);
        w_m2s.bready = 1'b0;
        r_m2s.rready = 1'b1;
        @(posedge clock); @(negedge clock);
        r_m2s.rready = 1'b0;
        $display("RW word=5 old=%h new=%h", 32'h0000_5555, 32'h0000_AAAA);

        // Reset during beat 2 of a 4-beat read
        r_m2s.arvalid = 1'b1; r_m2s.araddr = BASE; r_m2s.arlen = 8'd3;
        r_m2s.arsize = 3'd2;  r_m2s.arburst = 2'b01;
        wait_for(0, "rb_arready", c);
        @(posedge clock); @(negedge clock);
        r_m2s.arvalid = 1'b0;
        r_m2s.rready = 1'b1;
        wait_for(3, "rb_rvalid", c);
        @(posedge clock); @(negedge clock);
        check("rb_beat2", r_s2m.rdata, 32'h0000_1001);
        reset = 1'b1;
        @(posedge clock); @(negedge clock);
        check("rb_rvalid_off", 32'(r_s2m.rvalid), 32'd0);
        check("rb_arready_rst", 32'(r_s2m.arready), 32'd0);
        reset = 1'b0;
        r_m2s.rready = 1'b0;
        @(posedge clock); @(negedge clock);
        check("rb_arready_after", 32'(r_s2m.arready), 32'd1);
        check("rb_rvalid_after", 32'(r_s2m.rvalid), 32'd0);
        $display("RST mid-burst read abandoned");

        // Memory survives reset
        do_read(32'h8000_0004, 8'd0, 2'b01, 1'b0, d);
        check("mem_kept", d, 32'h0000_1001);

        // Address one full depth above base aliases word 0
        do_write(BASE + 32'(4 * DEPTH), 4'hF, 32'hA5A5_0001, 1, 2'b01);
        do_read(BASE, 8'd0, 2'b01, 1'b0, d);
        check("alias_word0", d, 32'hA5A5_0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
